// File: rtl/conv_inst_sequencer.sv
// Instruction sequencer for one 3x3 convolution tile: weight fetch, kernel load, execute, OFIFO drain.
// Optional `CONV_SEQ_RELU_EN sets relu on OFIFO reads of the last kij; otherwise bit 45 stays 0.
module conv_inst_sequencer #(
    parameter int ROW     = 8,
    parameter int COL     = 8,
    parameter int IN_W    = 6,
    parameter int KS      = 3,
    parameter int OUT_W   = 4,
    parameter int LEN_NIJ = 36,
    parameter int W_BASE  = 1024,
    parameter int GAP_CYC = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ofifo_valid,
    output logic [63:0] inst,
    output logic        busy,
    output logic        done,
    output logic [3:0]  kij_idx
);

    typedef enum logic [2:0] {
        S_IDLE, S_WFETCH, S_KLOAD, S_GAP, S_EXEC, S_DRAIN, S_NEXT, S_DONE
    } state_t;

    localparam logic [63:0] IDLE_WORD = 64'h0000_0001_000C_0000;
    localparam logic [7:0]  WF_LAST   = 8'(COL);
    localparam logic [7:0]  COL_M1    = 8'(COL - 1);
    localparam logic [7:0]  KL_LAST   = 8'(COL + ROW);
    localparam logic [7:0]  GAP_LAST  = 8'(GAP_CYC - 1);
    localparam logic [7:0]  EX_LAST   = 8'(LEN_NIJ - 1);
    localparam logic [7:0]  NIJ_END   = 8'(LEN_NIJ);
    localparam logic [3:0]  KIJ_LAST  = 4'(KS * KS - 1);
    localparam logic [3:0]  KX_LAST   = 4'(KS - 1);
    localparam logic [3:0]  NX_LAST   = 4'(IN_W - 1);
    localparam logic [3:0]  OUT_W4    = 4'(OUT_W);
    localparam logic [10:0] OUT_A     = 11'(OUT_W);
    localparam logic [10:0] COL_A     = 11'(COL);
    localparam logic [10:0] W_BASE_A  = 11'(W_BASE);

    state_t      state, state_n;
    logic [7:0]  t, t_n, t_sat, nij_cnt, nij_n;
    logic [3:0]  kij, kij_n, kx, kx_n, ky, ky_n;
    logic [3:0]  nx, nx_n, ny, ny_n, ox, oy;
    logic [10:0] a_hold, a_hold_n, a_calc;
    logic        pos_ok, busy_n, done_n;
    logic [63:0] inst_n;

    always_comb begin
        state_n  = state;
        t_n      = t + 8'd1;
        kij_n    = kij;
        kx_n     = kx;
        ky_n     = ky;
        nij_n    = nij_cnt;
        nx_n     = nx;
        ny_n     = ny;
        a_hold_n = a_hold;
        inst_n   = IDLE_WORD;
        busy_n   = (state != S_IDLE) && (state != S_DONE);
        done_n   = 1'b0;
        t_sat    = (t > COL_M1) ? COL_M1 : t;
        // Output position of the current OFIFO row; the >= tests stand in for signed compares.
        ox       = nx - kx;
        oy       = ny - ky;
        pos_ok   = (nx >= kx) && (ny >= ky) && (ox < OUT_W4) && (oy < OUT_W4);
        a_calc   = 11'(ox) + 11'(oy) * OUT_A;

        case (state)
            S_IDLE: begin
                t_n = 8'd0;
                if (start) begin
                    state_n = S_WFETCH;
                    kij_n = 4'd0; kx_n = 4'd0; ky_n = 4'd0;
                    nij_n = 8'd0; nx_n = 4'd0; ny_n = 4'd0;
                end
            end
            S_WFETCH: begin
                inst_n[19]   = 1'b0;
                inst_n[17:7] = W_BASE_A + 11'(kij) * COL_A + 11'(t_sat);
                inst_n[2]    = (t != 8'd0);
                if (t == WF_LAST) begin
                    state_n = S_KLOAD;
                    t_n = 8'd0;
                end
            end
            S_KLOAD: begin
                inst_n[3] = 1'b1;
                inst_n[0] = (t != 8'd0);
                if (t == KL_LAST) begin
                    state_n = S_GAP;
                    t_n = 8'd0;
                end
            end
            S_GAP: begin
                if (t == GAP_LAST) begin
                    state_n = S_EXEC;
                    t_n = 8'd0;
                end
            end
            S_EXEC: begin
                inst_n[19]   = 1'b0;
                inst_n[17:7] = 11'(t);
                inst_n[3:1]  = 3'b111;
                if (t == EX_LAST) begin
                    state_n = S_DRAIN;
                    t_n = 8'd0;
                end
            end
            S_DRAIN: begin
                if (nij_cnt == NIJ_END) state_n = S_NEXT;
            end
            S_NEXT: begin
                t_n = 8'd0;
                if (kij == KIJ_LAST) begin
                    state_n = S_DONE;
                end else begin
                    state_n = S_WFETCH;
                    kij_n = kij + 4'd1;
                    if (kx == KX_LAST) begin
                        kx_n = 4'd0;
                        ky_n = ky + 4'd1;
                    end else begin
                        kx_n = kx + 4'd1;
                    end
                    nij_n = 8'd0; nx_n = 4'd0; ny_n = 4'd0;
                end
            end
            S_DONE: begin
                done_n  = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        // OFIFO drain runs alongside streaming and never reads past LEN_NIJ rows.
        if (state == S_EXEC || state == S_DRAIN) begin
            inst_n[30:20] = a_hold;
            if (ofifo_valid && nij_cnt != NIJ_END) begin
                inst_n[6]  = 1'b1;
                inst_n[34] = (kij == 4'd0);
                inst_n[33] = (kij != 4'd0);
`ifdef CONV_SEQ_RELU_EN
                inst_n[45] = (kij == KIJ_LAST);
`endif
                nij_n = nij_cnt + 8'd1;
                if (nx == NX_LAST) begin
                    nx_n = 4'd0;
                    ny_n = ny + 4'd1;
                end else begin
                    nx_n = nx + 4'd1;
                end
                if (pos_ok) begin
                    inst_n[32]    = 1'b0;
                    inst_n[31]    = 1'b1;
                    inst_n[30:20] = a_calc;
                    a_hold_n      = a_calc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            t       <= 8'd0;
            kij     <= 4'd0;
            kx      <= 4'd0;
            ky      <= 4'd0;
            nij_cnt <= 8'd0;
            nx      <= 4'd0;
            ny      <= 4'd0;
            a_hold  <= 11'd0;
            inst    <= IDLE_WORD;
            busy    <= 1'b0;
            done    <= 1'b0;
            kij_idx <= 4'd0;
        end else begin
            state   <= state_n;
            t       <= t_n;
            kij     <= kij_n;
            kx      <= kx_n;
            ky      <= ky_n;
            nij_cnt <= nij_n;
            nx      <= nx_n;
            ny      <= ny_n;
            a_hold  <= a_hold_n;
            inst    <= inst_n;
            busy    <= busy_n;
            done    <= done_n;
            kij_idx <= kij;
        end
    end

endmodule
